upcount_monitor: RTL and testbench
==================================

# upcount_monitor

Stream checker that sits directly downstream of the free-running 8-bit up-counter stage and consumes its per-cycle output word. It verifies that each accepted sample equals the previous sample plus one, modulo 2^WIDTH, and declares lock after a run of correct increments. Once locked, it flags and counts every broken increment and counts clean wrap-arounds. Its status outputs feed the regression harness and on-chip debug.

## Interface
- WIDTH, 8, width of the monitored data word (2..16).
- LOCK_LEN, 4, consecutive correct increments required to declare lock (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- din  in  WIDTH  sample from the upstream counter.
- din_valid  in  1  sample qualifier; tie high when upstream emits every cycle.
- locked  out  1  registered; high while in LOCKED.
- err  out  1  registered one-cycle pulse on an increment error while LOCKED.
- err_count  out  8  registered error count, saturating at 0xFF.
- wrap_count  out  16  registered count of clean wraps (all-ones -> 0), saturating at 0xFFFF.

## Operation
- Internal state: prev (WIDTH), run_len (4 bits), FSM state in {EMPTY, ACQ, LOCKED}.
- A sample is accepted on a rising clk edge with din_valid=1.
- A sample matches when din == (prev + 1) mod 2^WIDTH. Compute in WIDTH bits and discard the carry. din == prev is a mismatch.
- Every accepted sample updates prev <= din, in every state.
- Cycles with din_valid=0 leave all state and outputs unchanged. There is no timeout. err is 0 on these cycles.
- EMPTY: the first accepted sample captures prev, sets run_len=0 and moves to ACQ. No comparison is made.
- ACQ on a match: run_len increments. When the incremented value equals LOCK_LEN, go to LOCKED and clear run_len.
- ACQ on a mismatch: run_len=0 and stay in ACQ. No err pulse and no err_count change.
- LOCKED on a match: stay in LOCKED.
- LOCKED on a mismatch: pulse err, increment err_count (saturating), go to ACQ with run_len=0. The mismatching sample becomes the new prev, so re-acquisition starts from it.
- A wrap is prev == all-ones and din == 0 on an accepted, matching sample. It increments wrap_count (saturating) in ACQ or LOCKED, never in EMPTY.
- Saturation: at 0xFF, err_count holds and err still pulses. At 0xFFFF, wrap_count holds.

## Timing
- Reset values: locked=0, err=0, err_count=0, wrap_count=0, state=EMPTY, prev=0, run_len=0.
- Reset takes effect immediately on rst rising, asynchronously. Release is synchronous to clk, and the first accepted sample after release is treated as the first sample.
- Latency is one clock. All outputs reflect the edge at which a sample was accepted and are valid right after it.
- locked rises after the edge that accepts the LOCK_LEN-th consecutive match. With the upstream counter and din_valid tied high, that is LOCK_LEN+1 accepted samples after reset release.
- On a LOCKED mismatch, err goes to 1 and locked goes to 0 after the same edge. err returns to 0 on the next edge.
- With LOCK_LEN=1, a single match after a mismatch re-locks. Back-to-back errors therefore produce err pulses on alternating samples at most.
- Wrap and error handling never coincide: a wrap is by definition a match.

## Test plan
- Lock acquisition (LOCK_LEN=4): reset, then din 0,1,2,3,4 with din_valid=1 each cycle. locked=0 through the 4th sample and 1 after the 5th. err never asserts; err_count=0, wrap_count=0.
- Wrap: once locked, feed 0xFD,0xFE,0xFF,0x00,0x01. wrap_count goes 0->1 after the 0x00 edge; locked stays 1; err stays 0.
- Error and relock: locked at 0x0A, feed 0x0B,0x0D. After 0x0D: err=1 for one cycle, err_count=1, locked=0. Then feed 0x0E..0x11: locked=1 after 0x11.
- Valid gaps: locked at 0x05, hold din_valid=0 for 3 cycles with din=0x55, then send 0x06 valid. No err, locked stays 1, counters unchanged.
- Saturation: alternate matching and mismatching samples until 300 errors are flagged (LOCK_LEN=1). err_count stops at 0xFF and err still pulses on each one.
- Asynchronous reset mid-lock: assert rst between edges while locked with err_count=3. locked, err_count and wrap_count go to 0 without a clock edge. After release, din 0x40,0x41,... requires a full LOCK_LEN re-acquisition.

Source files
------------

// File: rtl/upcount_monitor.sv
// upcount_monitor: checks that each accepted sample is the previous one plus one
// (mod 2^WIDTH). It acquires lock after LOCK_LEN clean increments, then flags and
// counts broken increments and counts clean wrap-arounds.
module upcount_monitor #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [15:0]      wrap_count
);

  typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_LEN4 = 4'(LOCK_LEN);

  state_t           state, stateNext;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prevInc;
  logic [3:0]       runLen, runLenNext, runInc;
  logic             match, isWrap;
  logic             errNext, wrapNext;

  // The carry out of prev+1 is dropped, so all-ones -> 0 counts as a match.
  assign prevInc = prev + WIDTH'(1);
  assign match   = (din == prevInc);
  assign isWrap  = match && (&prev);
  assign runInc  = runLen + 4'd1;

  // Next-state, run length and event pulses; invalid cycles keep everything as is.
  always_comb begin
    stateNext  = state;
    runLenNext = runLen;
    errNext    = 1'b0;
    wrapNext   = 1'b0;
    if (din_valid) begin
      case (state)
        EMPTY: begin
          // First sample only seeds prev; nothing to compare against yet.
          stateNext  = ACQ;
          runLenNext = 4'd0;
        end
        ACQ: begin
          if (match) begin
            wrapNext = isWrap;
            if (runInc == LOCK_LEN4) begin
              stateNext  = LOCKED;
              runLenNext = 4'd0;
            end else begin
              runLenNext = runInc;
            end
          end else begin
            runLenNext = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrapNext = isWrap;
          end else begin
            // Break lock; the bad sample becomes the new reference.
            errNext    = 1'b1;
            stateNext  = ACQ;
            runLenNext = 4'd0;
          end
        end
        default: begin
          stateNext  = EMPTY;
          runLenNext = 4'd0;
        end
      endcase
    end
  end

  // State, reference sample and run length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      prev   <= '0;
      runLen <= 4'd0;
    end else begin
      state  <= stateNext;
      runLen <= runLenNext;
      if (din_valid) prev <= din;
    end
  end

  // Registered status outputs with saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= 8'd0;
      wrap_count <= 16'd0;
    end else begin
      locked <= (stateNext == LOCKED);
      err    <= errNext;
      if (errNext && err_count != 8'hFF)       err_count  <= err_count + 8'd1;
      if (wrapNext && wrap_count != 16'hFFFF)  wrap_count <= wrap_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_upcount_monitor.sv
// Directed bench for upcount_monitor: one instance with LOCK_LEN=4, one with
// LOCK_LEN=1 for the error saturation run.
module tb_upcount_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din0 = '0, din1 = '0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic        locked0, err0, locked1, err1;
  logic [7:0]  errCnt0, errCnt1;
  logic [15:0] wrapCnt0, wrapCnt1;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  p1;

  always #5 clk = ~clk;

  upcount_monitor #(.WIDTH(8), .LOCK_LEN(4)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(vld0),
    .locked(locked0), .err(err0), .err_count(errCnt0), .wrap_count(wrapCnt0)
  );

  upcount_monitor #(.WIDTH(8), .LOCK_LEN(1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(vld1),
    .locked(locked1), .err(err1), .err_count(errCnt1), .wrap_count(wrapCnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp0(input string tag, input logic l, input logic e,
                      input logic [7:0] ec, input logic [15:0] wc);
    chk({tag, ".locked"}, 32'(locked0), 32'(l));
    chk({tag, ".err"},    32'(err0),    32'(e));
    chk({tag, ".errcnt"}, 32'(errCnt0), 32'(ec));
    chk({tag, ".wrap"},   32'(wrapCnt0), 32'(wc));
  endtask

  task automatic doReset();
    rst = 1'b1;
    vld0 = 1'b0;
    vld1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one cycle on u0 and return 1 time unit after the edge.
  task automatic send0(input logic [7:0] d, input logic v);
    din0 = d;
    vld0 = v;
    @(posedge clk); #1;
    vld0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d);
    din1 = d;
    vld1 = 1'b1;
    @(posedge clk); #1;
    vld1 = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    exp0("rst", 1'b0, 1'b0, 8'd0, 16'd0);
    chk("rst.u1.locked", 32'(locked1), 32'd0);

    // Lock acquisition: locked only after the 5th sample
    for (int i = 0; i < 5; i++) begin
      send0(8'(i), 1'b1);
      exp0($sformatf("acq%0d", i), (i == 4), 1'b0, 8'd0, 16'd0);
    end

    // Wrap: lock at 0xFC, then cross all-ones -> 0
    doReset();
    for (int i = 8'hF8; i <= 8'hFC; i++) send0(8'(i), 1'b1);
    exp0("wrapLock", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'hFD, 1'b1); exp0("wrapFD", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'hFE, 1'b1); exp0("wrapFE", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'hFF, 1'b1); exp0("wrapFF", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'h00, 1'b1); exp0("wrap00", 1'b1, 1'b0, 8'd0, 16'd1);
    send0(8'h01, 1'b1); exp0("wrap01", 1'b1, 1'b0, 8'd0, 16'd1);

    // Error and relock
    doReset();
    for (int i = 6; i <= 10; i++) send0(8'(i), 1'b1);
    exp0("errLock", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'h0B, 1'b1); exp0("err0B", 1'b1, 1'b0, 8'd0, 16'd0);
    send0(8'h0D, 1'b1); exp0("err0D", 1'b0, 1'b1, 8'd1, 16'd0);
    send0(8'h0E, 1'b1); exp0("err0E", 1'b0, 1'b0, 8'd1, 16'd0);
    send0(8'h0F, 1'b1); exp0("err0F", 1'b0, 1'b0, 8'd1, 16'd0);
    send0(8'h10, 1'b1); exp0("err10", 1'b0, 1'b0, 8'd1, 16'd0);
    send0(8'h11, 1'b1); exp0("err11", 1'b1, 1'b0, 8'd1, 16'd0);

    // Valid gaps hold everything
    doReset();
    for (int i = 1; i <= 5; i++) send0(8'(i), 1'b1);
    exp0("gapLock", 1'b1, 1'b0, 8'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      send0(8'h55, 1'b0);
      exp0($sformatf("gap%0d", i), 1'b1, 1'b0, 8'd0, 16'd0);
    end
    send0(8'h06, 1'b1); exp0("gap06", 1'b1, 1'b0, 8'd0, 16'd0);

    // Saturation on the LOCK_LEN=1 instance: 300 errors
    doReset();
    send1(8'h00);
    chk("sat.first.locked", 32'(locked1), 32'd0);
    send1(8'h01);
    chk("sat.lock", 32'(locked1), 32'd1);
    p1 = 8'h01;
    for (int i = 1; i <= 300; i++) begin
      p1 = p1 + 8'd2;
      send1(p1);
      chk($sformatf("sat%0d.err", i), 32'(err1), 32'd1);
      chk($sformatf("sat%0d.cnt", i), 32'(errCnt1), (i > 255) ? 32'd255 : 32'(i));
      p1 = p1 + 8'd1;
      send1(p1);
      chk($sformatf("sat%0d.relock", i), 32'(locked1), 32'd1);
      chk($sformatf("sat%0d.errlo", i), 32'(err1), 32'd0);
    end

    // Asynchronous reset while locked with err_count=3 and wrap_count=1
    doReset();
    for (int i = 8'hFC; i <= 8'hFF; i++) send0(8'(i), 1'b1);
    send0(8'h00, 1'b1);
    exp0("arLock", 1'b1, 1'b0, 8'd0, 16'd1);
    send0(8'h02, 1'b1);
    for (int i = 3; i <= 6; i++) send0(8'(i), 1'b1);
    send0(8'h08, 1'b1);
    for (int i = 9; i <= 12; i++) send0(8'(i), 1'b1);
    send0(8'h0E, 1'b1);
    for (int i = 15; i <= 18; i++) send0(8'(i), 1'b1);
    exp0("arPre", 1'b1, 1'b0, 8'd3, 16'd1);
    #2 rst = 1'b1;
    #1 exp0("arAsync", 1'b0, 1'b0, 8'd0, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send0(8'(8'h40 + i), 1'b1);
      exp0($sformatf("arReacq%0d", i), (i == 4), 1'b0, 8'd0, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
